// File: rtl/brick_render_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | brick_render_pkg : grid, brick-size and health/colour constants shared   |
// |                    by the level loader and the brick rasteriser.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package brick_render_pkg;

    localparam int c_grid_w     = 16;
    localparam int c_grid_h     = 4;
    localparam int c_num_bricks = c_grid_w * c_grid_h;
    localparam int c_brick_w    = 8;
    localparam int c_brick_h    = 2;
    localparam int c_coord_w    = 10;

    typedef enum logic [1:0] {
        HEALTH_NONE = 2'd0,
        HEALTH_LOW  = 2'd1,
        HEALTH_MID  = 2'd2,
        HEALTH_FULL = 2'd3
    } health_t;

    localparam logic [2:0] c_colour_none = 3'b000;
    localparam logic [2:0] c_colour_low  = 3'b100;
    localparam logic [2:0] c_colour_mid  = 3'b110;
    localparam logic [2:0] c_colour_full = 3'b010;

    function automatic logic [2:0] health_colour(input logic [1:0] h);
        case (health_t'(h))
            HEALTH_LOW:  return c_colour_low;
            HEALTH_MID:  return c_colour_mid;
            HEALTH_FULL: return c_colour_full;
            default:     return c_colour_none;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/brick_render_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | brick_render_if : per-brick draw stream from the level loader.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface brick_render_if;
    import brick_render_pkg::*;

    logic                 start;
    logic [c_coord_w-1:0] x_in;
    logic [c_coord_w-1:0] y_in;
    logic [c_coord_w-1:0] address;
    logic [1:0]           health;

    modport master (output start, x_in, y_in, address, health);
    modport slave  (input  start, x_in, y_in, address, health);
endinterface
`default_nettype wire

// File: rtl/brick_health_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | brick_health_ram : 2-bit health register file, synchronous write and    |
// |                    clear, asynchronous read (old data on same-cycle RW). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module brick_health_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [1:0]    wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [1:0]    rdata
);

    logic [1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/brick_render.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | brick_render : rasterises one brick per draw strobe onto the VGA plot    |
// |                bus and records its health in the brick health table.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module brick_render
    import brick_render_pkg::*;
#(
    parameter int BRICK_W    = c_brick_w,
    parameter int BRICK_H    = c_brick_h,
    parameter int Y_OFFSET   = 0,
    parameter int NUM_BRICKS = c_num_bricks
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    brick_render_if.slave   ldr,
    input  wire logic [5:0] rd_addr,
    output logic      [1:0] rd_health,
    output logic      [9:0] vga_x,
    output logic      [9:0] vga_y,
    output logic      [2:0] colour,
    output logic            plot,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    localparam int SH_X  = $clog2(BRICK_W);
    localparam int SH_Y  = $clog2(BRICK_H);
    localparam int COL_W = (BRICK_W > 1) ? SH_X : 1;
    localparam int ROW_W = (BRICK_H > 1) ? SH_Y : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_draw = 2'd1;
    localparam logic [1:0] c_st_fin  = 2'd2;

    logic [1:0]       r_state;
    logic [9:0]       r_base_x;
    logic [9:0]       r_base_y;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [9:0]       r_vga_x;
    logic [9:0]       r_vga_y;
    logic [2:0]       r_colour;
    logic             r_overrun;

    logic             w_accept;
    logic             w_we;
    logic             w_col_wrap;
    logic             w_last;
    logic [COL_W-1:0] w_next_col;
    logic [ROW_W-1:0] w_next_row;
    logic [9:0]       w_base_x;
    logic [9:0]       w_base_y;

    // Brick sizes are powers of two, so grid->pixel scaling is a plain shift.
    assign w_base_x = 10'(ldr.x_in << SH_X);
    assign w_base_y = 10'(Y_OFFSET + int'(ldr.y_in << SH_Y));

    assign w_accept   = ldr.start && ((r_state == c_st_idle) || (r_state == c_st_fin));
    assign w_we       = w_accept && (ldr.address < 10'(NUM_BRICKS));
    assign w_col_wrap = (r_col == COL_W'(BRICK_W - 1));
    assign w_last     = w_col_wrap && (r_row == ROW_W'(BRICK_H - 1));
    assign w_next_col = w_col_wrap ? '0 : r_col + 1'b1;
    assign w_next_row = w_col_wrap ? r_row + 1'b1 : r_row;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= c_st_idle;
            r_base_x  <= '0;
            r_base_y  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_vga_x   <= '0;
            r_vga_y   <= '0;
            r_colour  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (ldr.start && (r_state == c_st_draw)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                c_st_idle, c_st_fin: begin
                    if (w_accept) begin
                        r_state  <= c_st_draw;
                        r_base_x <= w_base_x;
                        r_base_y <= w_base_y;
                        r_col    <= '0;
                        r_row    <= '0;
                        // First pixel is presented in the cycle right after the strobe.
                        r_vga_x  <= w_base_x;
                        r_vga_y  <= w_base_y;
                        r_colour <= health_colour(ldr.health);
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_draw: begin
                    if (w_last) begin
                        r_state <= c_st_fin;
                    end else begin
                        r_col   <= w_next_col;
                        r_row   <= w_next_row;
                        r_vga_x <= r_base_x + 10'(w_next_col);
                        r_vga_y <= r_base_y + 10'(w_next_row);
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign vga_x   = r_vga_x;
    assign vga_y   = r_vga_y;
    assign colour  = r_colour;
    assign plot    = (r_state == c_st_draw);
    assign busy    = (r_state == c_st_draw);
    assign done    = (r_state == c_st_fin);
    assign overrun = r_overrun;

    brick_health_ram #(
        .DEPTH (64),
        .AW    (6)
    ) u_health_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (w_we),
        .waddr  (ldr.address[5:0]),
        .wdata  (ldr.health),
        .raddr  (rd_addr),
        .rdata  (rd_health)
    );

endmodule
`default_nettype wire

// File: tb/tb_brick_render.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_brick_render : directed self-checking bench for brick_render.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_brick_render;

    logic       clk;
    logic       resetn;
    logic [5:0] rd_addr;
    logic [1:0] rd_health;
    logic [9:0] vga_x;
    logic [9:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       overrun;

    int         vectors = 0;
    int         errors  = 0;
    logic [1:0] exp_tab [64];
    logic       seen_done;

    brick_render_if ldr ();

    brick_render dut (
        .clk       (clk),
        .resetn    (resetn),
        .ldr       (ldr),
        .rd_addr   (rd_addr),
        .rd_health (rd_health),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_brick(input int x, input int y, input int a, input int h);
        ldr.start   = 1'b1;
        ldr.x_in    = 10'(x);
        ldr.y_in    = 10'(y);
        ldr.address = 10'(a);
        ldr.health  = 2'(h);
    endtask

    // Pixel i of a brick at grid (x,y): row-major over an 8x2 block.
    task automatic chk_pixel(input int x, input int y, input logic [2:0] col, input int i);
        logic [23:0] exp;
        exp = {1'b1, 10'(x * 8 + (i % 8)), 10'(y * 2 + (i / 8)), col};
        check("pixel", {plot, vga_x, vga_y, colour}, {8'd0, exp});
    endtask

    // Entered in the first plot cycle; leaves the bench in the FIN cycle.
    task automatic draw(input int x, input int y, input logic [2:0] col, input int inj);
        for (int i = 0; i < 16; i++) begin
            chk_pixel(x, y, col, i);
            if (i == inj) start_brick(9, 2, 7, 2);
            tick();
            if (i == inj) ldr.start = 1'b0;
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("fin_plot", {31'd0, plot}, 32'd0);
        check("fin_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_tab[i] = 2'd0;
        resetn = 1'b0;
        rd_addr = 6'd0;
        start_brick(0, 0, 0, 0);
        ldr.start = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_plot", {31'd0, plot}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_xy", {12'd0, vga_x, vga_y}, 32'd0);
        check("rst_colour", {29'd0, colour}, 32'd0);
        check("rst_table", {30'd0, rd_health}, 32'd0);
        resetn = 1'b1;
        tick();

        // Basic draw: (24,2)..(31,3), green
        start_brick(3, 1, 19, 3);
        rd_addr = 6'd19;
        tick();
        ldr.start = 1'b0;
        draw(3, 1, 3'b010, -1);
        exp_tab[19] = 2'd3;
        check("basic_rd19", {30'd0, rd_health}, 32'd3);
        tick();
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_plot", {31'd0, plot}, 32'd0);

        // Prior health 2 at entry 0
        start_brick(0, 0, 0, 2);
        tick();
        ldr.start = 1'b0;
        draw(0, 0, 3'b110, -1);
        exp_tab[0] = 2'd2;
        tick();

        // Erase entry 0; same-cycle read returns the old value
        start_brick(0, 0, 0, 0);
        rd_addr = 6'd0;
        #1;
        check("rd_old", {30'd0, rd_health}, 32'd2);
        tick();
        check("rd_new", {30'd0, rd_health}, 32'd0);
        ldr.start = 1'b0;
        draw(0, 0, 3'b000, -1);
        exp_tab[0] = 2'd0;

        // Back-to-back: strobe in the FIN cycle, one-cycle plot gap
        start_brick(15, 3, 63, 1);
        tick();
        ldr.start = 1'b0;
        draw(15, 3, 3'b100, -1);
        exp_tab[63] = 2'd1;
        rd_addr = 6'd63;
        #1;
        check("b2b_rd63", {30'd0, rd_health}, 32'd1);
        check("no_overrun", {31'd0, overrun}, 32'd0);
        tick();

        // Overrun: strobe at cycle 5 of an active draw is ignored
        start_brick(2, 0, 5, 1);
        tick();
        ldr.start = 1'b0;
        draw(2, 0, 3'b100, 4);
        exp_tab[5] = 2'd1;
        check("overrun_set", {31'd0, overrun}, 32'd1);
        rd_addr = 6'd7;
        #1;
        check("overrun_rd7", {30'd0, rd_health}, 32'd0);
        tick();
        tick();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Out-of-range address: drawn, table untouched (70 would alias entry 6)
        start_brick(5, 2, 70, 3);
        tick();
        ldr.start = 1'b0;
        draw(5, 2, 3'b010, -1);
        tick();
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            #1;
            check("oor_table", {30'd0, rd_health}, {30'd0, exp_tab[a]});
            tick();
        end

        // Reset mid-draw at pixel 8
        start_brick(1, 1, 10, 2);
        tick();
        ldr.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_pixel(1, 1, 3'b110, i);
            if (i < 8) tick();
        end
        resetn = 1'b0;
        tick();
        check("mid_rst_plot", {31'd0, plot}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        seen_done = done;
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            seen_done = seen_done | done | plot;
        end
        check("mid_rst_quiet", {31'd0, seen_done}, 32'd0);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            #1;
            check("rst_table_scan", {30'd0, rd_health}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
